spi_frame_dispenser: RTL and testbench

- Parametrised frame parser between the SPI byte receiver and the colour/PWM pipeline.
- Hunts for a sync byte, then collects NUM_FIELDS payload bytes, then an optional checksum byte.
- All output fields are committed atomically only when a frame completes cleanly.
- Adds rdy synchronisation, an inter-byte timeout and error reporting; downstream logic never sees a half-updated frame.

---
 rtl/rgbw_pkg.sv | 27 ++
 rtl/rdy_edge_sync.sv | 25 ++
 rtl/spi_frame_dispenser.sv | 140 ++++++++++++++
 tb/tb_spi_frame_dispenser.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// Shared types and constants for the RGBW SPI front end.
package rgbw_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_FIELDS = 7;
  localparam logic [7:0]  DEF_SYNC_BYTE  = 8'h55;
  localparam int unsigned ERR_CNT_W      = 8;

  localparam int unsigned FLD_LINT  = 0;
  localparam int unsigned FLD_CIDX  = 1;
  localparam int unsigned FLD_RED   = 2;
  localparam int unsigned FLD_GREEN = 3;
  localparam int unsigned FLD_BLUE  = 4;
  localparam int unsigned FLD_WHITE = 5;
  localparam int unsigned FLD_MODE  = 6;

  // Increment that sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rdy_edge_sync.sv
// Brings an asynchronous ready level into clk and flags each rising edge once.
module rdy_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic rdy,
  output logic rise_c
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rdy;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/spi_frame_dispenser.sv
// Sync-byte framed parser: collects payload fields and commits them atomically
// once the frame (and optional checksum) completes; reports checksum/timeout errors.
module spi_frame_dispenser
  import rgbw_pkg::*;
#(
  parameter int unsigned       NUM_FIELDS  = DEF_NUM_FIELDS,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(DEF_SYNC_BYTE),
  parameter bit                CHECKSUM_EN = 1'b1,
  parameter int unsigned       TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            rx_byte,
  input  logic                         rx_rdy,
  output logic [NUM_FIELDS*DATA_W-1:0] fields,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [ERR_CNT_W-1:0]         err_cnt,
  output logic                         busy
);

  localparam int unsigned FW = NUM_FIELDS * DATA_W;
  localparam int unsigned IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_FIELDS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [FW-1:0]     shadow;
  logic [FW-1:0]     shadow_merged_c;
  logic [IW-1:0]     index;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_plus_c;
  logic [TW-1:0]     timer;
  logic              acc_c;
  logic              timeout_c;

  rdy_edge_sync u_rdy_sync (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rx_rdy),
    .rise_c (acc_c)
  );

  // Shadow image with the byte being accepted already written in place.
  always_comb begin
    shadow_merged_c = shadow;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (index == IW'(i)) shadow_merged_c[i*DATA_W +: DATA_W] = rx_byte;
    end
  end

  assign sum_plus_c = sum + rx_byte;
  assign timeout_c  = !acc_c && (timer == TIMER_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HUNT;
      shadow      <= '0;
      index       <= '0;
      sum         <= '0;
      timer       <= '0;
      fields      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        HUNT: begin
          if (acc_c && (rx_byte == SYNC_BYTE)) begin
            state  <= PAYLOAD;
            busy   <= 1'b1;
            index  <= '0;
            sum    <= '0;
            timer  <= '0;
            shadow <= '0;
          end
        end
        PAYLOAD: begin
          if (acc_c) begin
            shadow <= shadow_merged_c;
            sum    <= sum_plus_c;
            timer  <= '0;
            if (index == LAST_IDX) begin
              if (CHECKSUM_EN) begin
                state <= CHECK;
              end else begin
                fields      <= shadow_merged_c;
                frame_valid <= 1'b1;
                state       <= HUNT;
                busy        <= 1'b0;
              end
            end else begin
              index <= index + 1'b1;
            end
          end else if (timeout_c) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state     <= HUNT;
            busy      <= 1'b0;
            shadow    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (acc_c) begin
            if (sum_plus_c == '0) begin
              fields      <= shadow;
              frame_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
            end
            state  <= HUNT;
            busy   <= 1'b0;
            shadow <= '0;
          end else if (timeout_c) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
            state     <= HUNT;
            busy      <= 1'b0;
            shadow    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_dispenser.sv
// Randomised scoreboard bench for spi_frame_dispenser against a byte-list frame model.
`timescale 1ns/1ps
module tb_spi_frame_dispenser;
  import rgbw_pkg::*;

  localparam int unsigned NF   = DEF_NUM_FIELDS;
  localparam int unsigned FW   = NF * 8;
  localparam int unsigned TO   = 4096;
  localparam logic [7:0]  SYNC = DEF_SYNC_BYTE;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_rdy = 1'b0;
  logic [FW-1:0] fields;
  logic          frame_valid;
  logic          frame_err;
  logic [7:0]    err_cnt;
  logic          busy;

  spi_frame_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_rdy      (rx_rdy),
    .fields      (fields),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [FW-1:0] f;
    logic [7:0]    ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: frame = SYNC, NF payload bytes, checksum making the byte sum zero.
  bit            m_in = 1'b0;
  logic [7:0]    m_bytes[$];
  logic [FW-1:0] m_fields = '0;
  int            m_err = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  function automatic void model_error();
    exp_t e;
    if (m_err < 255) m_err++;
    e.is_err = 1'b1;
    e.f      = m_fields;
    e.ec     = 8'(m_err);
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    exp_t e;
    int   s;
    if (!m_in) begin
      if (b == SYNC) begin
        m_in = 1'b1;
        m_bytes.delete();
      end
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == NF + 1) begin
        s = 0;
        foreach (m_bytes[i]) s += int'(m_bytes[i]);
        if (s % 256 == 0) begin
          for (int i = 0; i < NF; i++) m_fields[i*8 +: 8] = m_bytes[i];
          e.is_err = 1'b0;
          e.f      = m_fields;
          e.ec     = 8'(m_err);
          exp_q.push_back(e);
        end else begin
          model_error();
        end
        m_in = 1'b0;
      end
    end
  endfunction

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge clk) begin
    if (reset && (frame_valid || frame_err)) begin
      chk("pulse_exclusive", 64'(frame_valid & frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none at %0t",
                 frame_valid, frame_err, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_kind", 64'(frame_err), 64'(e.is_err));
        chk("evt_fields", 64'(fields), 64'(e.f));
        chk("evt_err_cnt", 64'(err_cnt), 64'(e.ec));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if (n > int'(TO) + 8 && m_in) begin
      m_in = 1'b0;
      model_error();
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FW-1:0] p, input bit corrupt);
    logic [7:0] s;
    s = 8'h00;
    send_byte(SYNC);
    for (int i = 0; i < NF; i++) begin
      send_byte(p[i*8 +: 8]);
      s = s + p[i*8 +: 8];
    end
    s = 8'h00 - s;
    if (corrupt) s = s + 8'h01;
    send_byte(s);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    m_in     = 1'b0;
    m_fields = '0;
    m_err    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fields", 64'(fields), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_pulses", 64'({frame_valid, frame_err}), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_payload();
    logic [FW-1:0] p;
    for (int i = 0; i < NF; i++) p[i*8 +: 8] = 8'($urandom);
    return p;
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] g;
    g = 8'($urandom);
    if (g == SYNC) g = 8'hAA;
    return g;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] p;
    logic [FW-1:0] prev;
    int            kind;

    @(posedge clk);
    #1;
    do_reset();

    // Basic frame, fields 6..0 = 70..10.
    for (int i = 0; i < NF; i++) p[i*8 +: 8] = 8'((i + 1) * 8'h10);
    send_frame(p, 1'b0);
    chk("basic_fields", 64'(fields), 64'(p));
    chk("basic_red", 64'(fields[FLD_RED*8 +: 8]), 64'h30);
    chk("basic_mode", 64'(fields[FLD_MODE*8 +: 8]), 64'h70);
    chk("basic_err_cnt", 64'(err_cnt), 64'd0);
    chk("basic_busy", 64'(busy), 64'd0);

    // Garbage while hunting is ignored.
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h13);
    chk("garbage_busy", 64'(busy), 64'd0);
    p = rand_payload();
    send_frame(p, 1'b0);
    chk("garbage_then_frame", 64'(fields), 64'(p));

    // Bad checksum leaves fields untouched.
    prev = p;
    send_frame(rand_payload(), 1'b1);
    chk("badchk_err_cnt", 64'(err_cnt), 64'd1);
    chk("badchk_fields", 64'(fields), 64'(prev));

    // Mid-frame stall times out and drops back to hunting.
    send_byte(SYNC);
    chk("stall_busy_hi", 64'(busy), 64'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(int'(TO) + 200);
    chk("timeout_busy_lo", 64'(busy), 64'd0);
    chk("timeout_err_cnt", 64'(err_cnt), 64'd2);
    chk("timeout_fields", 64'(fields), 64'(prev));
    p = rand_payload();
    send_frame(p, 1'b0);
    chk("after_timeout_fields", 64'(fields), 64'(p));

    // Sync value inside the payload is ordinary data.
    p = rand_payload();
    p[FLD_CIDX*8 +: 8] = SYNC;
    send_frame(p, 1'b0);
    chk("sync_as_data", 64'(fields[15:8]), 64'h55);
    chk("sync_as_data_all", 64'(fields), 64'(p));

    // Reset in the middle of a frame discards it.
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    chk("midframe_busy", 64'(busy), 64'd1);
    do_reset();
    p = rand_payload();
    send_frame(p, 1'b0);
    chk("post_reset_fields", 64'(fields), 64'(p));

    // Randomised mix of frame shapes.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      p = rand_payload();
      if (kind == 2) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) send_byte(rand_garbage());
      end
      if (kind == 3) p[$urandom_range(0, NF - 1) * 8 +: 8] = SYNC;
      send_frame(p, kind == 1);
      idle(int'($urandom_range(0, 20)));
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) send_frame(rand_payload(), 1'b1);
    chk("err_cnt_saturated", 64'(err_cnt), 64'd255);
    chk("saturated_fields", 64'(fields), 64'(m_fields));

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
